// File: rtl/prng_arbiter.sv
// prng_arbiter
//   Shares one Xoroshiro32PlusPlus generator between NUM_REQ consumers.
//   Arbitration is round-robin. Each generator word goes to exactly one
//   requester, and io_prngNext advances the generator once per delivery.
//   Each delivery takes three cycles: IDLE (pick winner), DELIVER (register
//   word/ack/strobe), SETTLE (outputs visible, generator steps).
//
// Ports
//   clk           system clock (clock_50 domain)
//   reset         synchronous, active-high
//   io_req        per-requester request level
//   io_ack        one-hot, one-cycle ack pulse; io_data is valid with it
//   io_data       delivered word (registered, holds between acks)
//   io_grantId    index of the acked requester, 0 when no ack
//   io_busy       high in DELIVER and SETTLE
//   io_prngNext   one-cycle advance strobe to the generator io_next
//   io_prngValue  generator output (current state)
//
// Optional feature, enabled by defining PRNG_ARB_STATS_EN:
//   io_statSel    requester whose grant count is read back
//   io_statCount  registered 16-bit saturating grant count, 0 if sel out of range
module prng_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned IDX_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] io_req,
    output logic [NUM_REQ-1:0] io_ack,
    output logic [WIDTH-1:0]   io_data,
    output logic [IDX_W-1:0]   io_grantId,
    output logic               io_busy,
    output logic               io_prngNext,
    input  logic [WIDTH-1:0]   io_prngValue
`ifdef PRNG_ARB_STATS_EN
    ,
    input  logic [IDX_W-1:0]   io_statSel,
    output logic [15:0]        io_statCount
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        DELIVER,
        SETTLE
    } state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   rr_ptr, rr_nx;
    logic [IDX_W-1:0]   win, win_nx;
    logic [NUM_REQ-1:0] ack_nx;
    logic [WIDTH-1:0]   data_nx;
    logic [IDX_W-1:0]   grant_nx;
    logic               next_nx;
    logic               found;
    logic [31:0]        scan;

    assign io_busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        win_nx   = win;
        ack_nx   = '0;
        data_nx  = io_data;
        grant_nx = '0;
        next_nx  = 1'b0;
        found    = 1'b0;
        scan     = '0;
        case (state)
            IDLE: begin
                // First set request at or above rr_ptr, wrapping around.
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    scan = (32'(rr_ptr) + k) % NUM_REQ;
                    if (!found && io_req[scan]) begin
                        found  = 1'b1;
                        win_nx = IDX_W'(scan);
                    end
                end
                if (found) state_nx = DELIVER;
            end
            DELIVER: begin
                // Word sampled before the advance, so deliveries follow the
                // generator sequence exactly.
                data_nx  = io_prngValue;
                ack_nx   = NUM_REQ'(1) << win;
                grant_nx = win;
                next_nx  = 1'b1;
                rr_nx    = IDX_W'((32'(win) + 1) % NUM_REQ);
                state_nx = SETTLE;
            end
            SETTLE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            win         <= '0;
            io_ack      <= '0;
            io_data     <= '0;
            io_grantId  <= '0;
            io_prngNext <= 1'b0;
        end else begin
            state       <= state_nx;
            rr_ptr      <= rr_nx;
            win         <= win_nx;
            io_ack      <= ack_nx;
            io_data     <= data_nx;
            io_grantId  <= grant_nx;
            io_prngNext <= next_nx;
        end
    end

`ifdef PRNG_ARB_STATS_EN
    logic [15:0] stat_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
            io_statCount <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (io_ack[i] && stat_cnt[i] != 16'hFFFF)
                    stat_cnt[i] <= stat_cnt[i] + 16'd1;
            end
            if (32'(io_statSel) < NUM_REQ)
                io_statCount <= stat_cnt[io_statSel];
            else
                io_statCount <= '0;
        end
    end
`endif

endmodule
